array_wr_ctrl: RTL and testbench
================================

# array_wr_ctrl

Write-side array controller for the memory controller. It accepts write frames from the FSM/AXI frame path, opens the addressed row, and issues one column strobe per frame with its write data. It then honours write recovery, tRAS and tRP, and pulses `wr_done`. It drives the write copy of the array interface toward `array_if_sel`, using the same pin protocol the read controller uses in the opposite direction.

## Interface
- `AXI_ADDR_WIDTH`, 20: frame address width.
- `AXI_DATA_WIDTH`, 64: frame data width.
- `AXI_FRAME_WIDTH`, `AXI_ADDR_WIDTH+AXI_DATA_WIDTH+3`: frame width.
- `AXI_RADDR_WIDTH`, 14: row address width, taken from the upper address bits.
- `AXI_CADDR_WIDTH`, `AXI_ADDR_WIDTH-AXI_RADDR_WIDTH`: column address width, taken from the lower address bits.

Ports (the design uses one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `mc_tras_cfg` in 8: minimum number of cycles `array_banksel_n_wr` stays low.
- `mc_trp_cfg` in 8: precharge cycles before `wr_done`.
- `mc_trcd_cfg` in 8: cycles from activate to the first column strobe.
- `mc_twr_cfg` in 8: write recovery cycles after the last strobe.
- `axi_frame_wr_data` in `AXI_FRAME_WIDTH`: frame fields, MSB first:
  - `sof`
  - `eof`
  - `wr` (1 = write)
  - `addr` = {raddr, caddr}
  - `data`
- `axi_frame_wr_valid` in 1: frame valid.
- `axi_frame_wr_ready` out 1: frame accepted when valid && ready.
- `wr_done` out 1: one-cycle pulse when the burst is complete and the bank is precharged.
- `array_banksel_n_wr` out 1: active-low bank select / row open.
- `array_raddr_wr` out `AXI_RADDR_WIDTH`: row address.
- `array_cas_wr` out 1: column strobe.
- `array_caddr_wr` out `AXI_CADDR_WIDTH`: column address.
- `array_wdata_wr` out `AXI_DATA_WIDTH`: write data, valid while `array_cas_wr`=1.

## Operation
States: IDLE, ACT, WR, CAS, TWR, RAS_WAIT, PRE, DONE.

- **IDLE**: `ready`=0.
  - valid && `sof` && `wr`: latch raddr, drive `banksel_n`=0 next cycle, go to ACT. The frame is not consumed here.
  - valid && !`sof`: the frame is consumed (`ready`=1) and discarded, with no array activity.
- **ACT**: lasts max(`mc_trcd_cfg`,1) cycles, then go to WR.
- **WR**: `ready`=1. On handshake, register caddr/data onto the array outputs and go to CAS.
  - `sof`, `wr` and raddr are ignored for every frame after the first.
- **CAS**: `array_cas_wr`=1 for exactly one cycle and `ready`=0.
  - Next state is TWR if the accepted frame had `eof`, otherwise WR. Going back to WR drops `cas` to 0 and raises `ready` in the same cycle.
- **TWR**: lasts max(`mc_twr_cfg`,1) cycles.
- **RAS_WAIT**: holds until `banksel_n` has been low for at least `mc_tras_cfg` cycles. It takes zero cycles if that is already met.
- **PRE**: `banksel_n`=1 for max(`mc_trp_cfg`,1) cycles.
- **DONE**: `wr_done`=1 for one cycle, then go to IDLE.

Counters and data paths:
- The tRAS counter is 8 bits, starts at the first low cycle and saturates at 255.
- `caddr`/`wdata` hold their last values outside CAS.
- `raddr` holds until the next activate.

## Timing
- All outputs are registered.
- Reset values: `ready`=0, `wr_done`=0, `banksel_n`=1, `cas`=0, raddr/caddr/wdata=0, state IDLE.
- Reset asserted mid-burst: the bank closes immediately (`banksel_n`=1), no `wr_done` is issued, and frames in flight are lost.
- Beat throughput is one frame per 2 cycles; `cas` is never high in two consecutive cycles.
- Worked example, with the detecting cycle numbered 0:
  - `banksel_n`=0 from cycle 1.
  - First handshake at cycle 1+trcd; its strobe follows one cycle later.
- Configuration registers are sampled continuously and must be held stable while a burst is active.

## Configuration
- `ARRAY_WR_ROW_CHECK_EN` defined:
  - Adds output `wr_row_err` (1 bit, reset 0).
  - It pulses for one cycle, coincident with CAS, when a non-first frame's raddr differs from the open row.
  - That beat is still written to the open row.
- `ARRAY_WR_ROW_CHECK_EN` undefined: the port does not exist and raddr bits of non-first frames are ignored.

## Test plan
All scenarios use tras=16, trp=6, trcd=7, twr=4, with IDLE detecting the frame at cycle 0.
- Single frame {1,1,1,addr=100,data=0xA5}:
  - `banksel_n`=0 at cycle 1.
  - Handshake at cycle 8.
  - `cas`=1 at cycle 9 with caddr=36 and wdata=0xA5.
  - `banksel_n`=1 at cycle 17.
  - `wr_done` at cycle 23.
- Four-frame burst, addr 100..103:
  - Handshakes at cycles 8, 10, 12, 14.
  - `cas` at cycles 9, 11, 13, 15 with caddr 36..39.
  - `banksel_n`=1 at cycle 20.
  - `wr_done` at cycle 26.
- Valid deasserted for 5 cycles mid-burst: `ready` stays 1 in WR, no strobe is issued, and the burst resumes correctly.
- Frame with `sof`=0 in IDLE: accepted in 1 cycle, with `banksel_n`, `cas` and `wr_done` all staying inactive.
- Reset pulse at cycle 11 of a burst: all outputs return to reset values within the same cycle, and the next frame starts a clean burst.
- With `ARRAY_WR_ROW_CHECK_EN`, second frame addr=(5<<6)|3 while row 1 is open: `wr_row_err` pulses with `cas`, and caddr=3.

Source files
------------

// File: rtl/array_wr_ctrl_if.sv
// array_wr_ctrl_if: frame input, timing configuration and write-side array pins
// of array_wr_ctrl. The frame source / array consumer uses the master modport;
// the controller uses slave. wr_row_err exists only with ARRAY_WR_ROW_CHECK_EN.
interface array_wr_ctrl_if #(
  parameter int unsigned AXI_ADDR_WIDTH  = 20,
  parameter int unsigned AXI_DATA_WIDTH  = 64,
  parameter int unsigned AXI_RADDR_WIDTH = 14
);
  localparam int unsigned AXI_FRAME_WIDTH = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + 3;
  localparam int unsigned AXI_CADDR_WIDTH = AXI_ADDR_WIDTH - AXI_RADDR_WIDTH;

  logic [7:0]                 mc_tras_cfg;
  logic [7:0]                 mc_trp_cfg;
  logic [7:0]                 mc_trcd_cfg;
  logic [7:0]                 mc_twr_cfg;
  logic [AXI_FRAME_WIDTH-1:0] axi_frame_wr_data;
  logic                       axi_frame_wr_valid;
  logic                       axi_frame_wr_ready;
  logic                       wr_done;
  logic                       array_banksel_n_wr;
  logic [AXI_RADDR_WIDTH-1:0] array_raddr_wr;
  logic                       array_cas_wr;
  logic [AXI_CADDR_WIDTH-1:0] array_caddr_wr;
  logic [AXI_DATA_WIDTH-1:0]  array_wdata_wr;
`ifdef ARRAY_WR_ROW_CHECK_EN
  logic                       wr_row_err;
`endif

  modport master (
`ifdef ARRAY_WR_ROW_CHECK_EN
    input  wr_row_err,
`endif
    output mc_tras_cfg, mc_trp_cfg, mc_trcd_cfg, mc_twr_cfg,
    output axi_frame_wr_data, axi_frame_wr_valid,
    input  axi_frame_wr_ready, wr_done,
    input  array_banksel_n_wr, array_raddr_wr, array_cas_wr,
    input  array_caddr_wr, array_wdata_wr
  );

  modport slave (
`ifdef ARRAY_WR_ROW_CHECK_EN
    output wr_row_err,
`endif
    input  mc_tras_cfg, mc_trp_cfg, mc_trcd_cfg, mc_twr_cfg,
    input  axi_frame_wr_data, axi_frame_wr_valid,
    output axi_frame_wr_ready, wr_done,
    output array_banksel_n_wr, array_raddr_wr, array_cas_wr,
    output array_caddr_wr, array_wdata_wr
  );
endinterface

// File: rtl/array_wr_ctrl.sv
// array_wr_ctrl: write-side array controller. Opens the row of a burst's first
// frame, issues one column strobe per accepted frame, then honours tWR, tRAS and
// tRP before pulsing wr_done. Optional macro ARRAY_WR_ROW_CHECK_EN adds
// wr_row_err, flagging non-first frames whose row differs from the open row.
module array_wr_ctrl #(
  parameter int unsigned AXI_ADDR_WIDTH  = 20,
  parameter int unsigned AXI_DATA_WIDTH  = 64,
  parameter int unsigned AXI_RADDR_WIDTH = 14
) (
  input logic            clk,
  input logic            rst,
  array_wr_ctrl_if.slave bus
);
  localparam int unsigned AXI_FRAME_WIDTH = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + 3;
  localparam int unsigned AXI_CADDR_WIDTH = AXI_ADDR_WIDTH - AXI_RADDR_WIDTH;
  localparam int unsigned SOF_BIT         = AXI_FRAME_WIDTH - 1;
  localparam int unsigned EOF_BIT         = AXI_FRAME_WIDTH - 2;
  localparam int unsigned WR_BIT          = AXI_FRAME_WIDTH - 3;

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_WR, S_CAS, S_TWR, S_RAS_WAIT, S_PRE, S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [7:0]                 tmr_q, tmr_d;
  logic [7:0]                 ras_cnt_q, ras_cnt_d;
  logic                       ready_q, ready_d;
  logic                       done_q, done_d;
  logic                       banksel_n_q, banksel_n_d;
  logic                       cas_q, cas_d;
  logic                       eof_q, eof_d;
  logic [AXI_RADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [AXI_CADDR_WIDTH-1:0] caddr_q, caddr_d;
  logic [AXI_DATA_WIDTH-1:0]  wdata_q, wdata_d;
`ifdef ARRAY_WR_ROW_CHECK_EN
  logic                       first_q, first_d;
  logic                       row_err_q, row_err_d;
`endif

  logic                       f_sof, f_eof, f_wr, hs;
  logic [AXI_ADDR_WIDTH-1:0]  f_addr;
  logic [AXI_DATA_WIDTH-1:0]  f_data;
  logic [AXI_RADDR_WIDTH-1:0] f_raddr;
  logic [AXI_CADDR_WIDTH-1:0] f_caddr;

  // Frame field split and handshake
  assign f_sof   = bus.axi_frame_wr_data[SOF_BIT];
  assign f_eof   = bus.axi_frame_wr_data[EOF_BIT];
  assign f_wr    = bus.axi_frame_wr_data[WR_BIT];
  assign f_addr  = bus.axi_frame_wr_data[AXI_DATA_WIDTH +: AXI_ADDR_WIDTH];
  assign f_data  = bus.axi_frame_wr_data[AXI_DATA_WIDTH-1:0];
  assign f_raddr = f_addr[AXI_ADDR_WIDTH-1 -: AXI_RADDR_WIDTH];
  assign f_caddr = f_addr[AXI_CADDR_WIDTH-1:0];
  assign hs      = bus.axi_frame_wr_valid && ready_q;

  // Timer reload so that a phase lasts max(cfg,1) cycles
  function automatic logic [7:0] load_of(input logic [7:0] cfg);
    return (cfg == 8'd0) ? 8'd0 : cfg - 8'd1;
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    ras_cnt_d   = ras_cnt_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    cas_d       = 1'b0;
    banksel_n_d = banksel_n_q;
    eof_d       = eof_q;
    raddr_d     = raddr_q;
    caddr_d     = caddr_q;
    wdata_d     = wdata_q;
`ifdef ARRAY_WR_ROW_CHECK_EN
    first_d     = first_q;
    row_err_d   = 1'b0;
`endif
    // tRAS counter: counts cycles with the row open, saturating at 255
    if (!banksel_n_q && ras_cnt_q != 8'hFF) ras_cnt_d = ras_cnt_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          ready_d = 1'b0;                  // stray frame consumed and dropped
        end else if (bus.axi_frame_wr_valid) begin
          if (f_sof && f_wr) begin
            state_d     = S_ACT;
            banksel_n_d = 1'b0;
            raddr_d     = f_raddr;
            tmr_d       = load_of(bus.mc_trcd_cfg);
            ras_cnt_d   = 8'd1;
            ready_d     = 1'b0;
`ifdef ARRAY_WR_ROW_CHECK_EN
            first_d     = 1'b1;
`endif
          end else begin
            ready_d = 1'b1;
          end
        end else begin
          ready_d = 1'b0;
        end
      end
      S_ACT: begin
        if (tmr_q == 8'd0) begin
          state_d = S_WR;
          ready_d = 1'b1;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      S_WR: begin
        if (hs) begin
          state_d = S_CAS;
          ready_d = 1'b0;
          cas_d   = 1'b1;
          caddr_d = f_caddr;
          wdata_d = f_data;
          eof_d   = f_eof;
`ifdef ARRAY_WR_ROW_CHECK_EN
          first_d   = 1'b0;
          row_err_d = !first_q && (f_raddr != raddr_q);
`endif
        end
      end
      S_CAS: begin
        if (eof_q) begin
          state_d = S_TWR;
          tmr_d   = load_of(bus.mc_twr_cfg);
        end else begin
          state_d = S_WR;
          ready_d = 1'b1;
        end
      end
      S_TWR: begin
        if (tmr_q != 8'd0) begin
          tmr_d = tmr_q - 8'd1;
        end else if (ras_cnt_q >= bus.mc_tras_cfg) begin
          state_d     = S_PRE;
          banksel_n_d = 1'b1;
          tmr_d       = load_of(bus.mc_trp_cfg);
        end else begin
          state_d = S_RAS_WAIT;
        end
      end
      S_RAS_WAIT: begin
        if (ras_cnt_q >= bus.mc_tras_cfg) begin
          state_d     = S_PRE;
          banksel_n_d = 1'b1;
          tmr_d       = load_of(bus.mc_trp_cfg);
        end
      end
      S_PRE: begin
        if (tmr_q == 8'd0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        banksel_n_d = 1'b1;
        ready_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset closes the bank at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tmr_q       <= 8'd0;
      ras_cnt_q   <= 8'd0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      banksel_n_q <= 1'b1;
      cas_q       <= 1'b0;
      eof_q       <= 1'b0;
      raddr_q     <= '0;
      caddr_q     <= '0;
      wdata_q     <= '0;
`ifdef ARRAY_WR_ROW_CHECK_EN
      first_q     <= 1'b0;
      row_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      ras_cnt_q   <= ras_cnt_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      banksel_n_q <= banksel_n_d;
      cas_q       <= cas_d;
      eof_q       <= eof_d;
      raddr_q     <= raddr_d;
      caddr_q     <= caddr_d;
      wdata_q     <= wdata_d;
`ifdef ARRAY_WR_ROW_CHECK_EN
      first_q     <= first_d;
      row_err_q   <= row_err_d;
`endif
    end
  end

  // Output drive
  assign bus.axi_frame_wr_ready = ready_q;
  assign bus.wr_done            = done_q;
  assign bus.array_banksel_n_wr = banksel_n_q;
  assign bus.array_raddr_wr     = raddr_q;
  assign bus.array_cas_wr       = cas_q;
  assign bus.array_caddr_wr     = caddr_q;
  assign bus.array_wdata_wr     = wdata_q;
`ifdef ARRAY_WR_ROW_CHECK_EN
  assign bus.wr_row_err         = row_err_q;
`endif
endmodule

// File: tb/tb_array_wr_ctrl.sv
// tb_array_wr_ctrl: scoreboard bench for array_wr_ctrl. The driver pushes the
// expected strobes and completion timing of each burst; a monitor pops and
// compares whenever the DUT strobes, precharges or signals done.
module tb_array_wr_ctrl;
  localparam int unsigned A = 20;
  localparam int unsigned D = 64;
  localparam int unsigned R = 14;
  localparam int unsigned C = A - R;
  localparam int MAXW = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   trcd_v, twr_v, tras_v, trp_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  array_wr_ctrl_if #(.AXI_ADDR_WIDTH(A), .AXI_DATA_WIDTH(D), .AXI_RADDR_WIDTH(R)) bus ();
  array_wr_ctrl #(.AXI_ADDR_WIDTH(A), .AXI_DATA_WIDTH(D), .AXI_RADDR_WIDTH(R)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  typedef struct { int cyc; logic [C-1:0] caddr; logic [D-1:0] data; bit err; } beat_t;
  typedef struct { int rise; int done; } done_t;
  beat_t beat_q[$];
  done_t done_q[$];
  logic [A-1:0] f_addr[$];
  logic [D-1:0] f_data[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int m1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic set_cfg(input int tras, input int trp, input int trcd, input int twr);
    tras_v = tras; trp_v = trp; trcd_v = trcd; twr_v = twr;
    bus.mc_tras_cfg = 8'(tras);
    bus.mc_trp_cfg  = 8'(trp);
    bus.mc_trcd_cfg = 8'(trcd);
    bus.mc_twr_cfg  = 8'(twr);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", 64'(bus.axi_frame_wr_ready), 0);
    chk("rst_wr_done", 64'(bus.wr_done), 0);
    chk("rst_banksel_n", 64'(bus.array_banksel_n_wr), 1);
    chk("rst_cas", 64'(bus.array_cas_wr), 0);
    chk("rst_raddr", 64'(bus.array_raddr_wr), 0);
    chk("rst_caddr", 64'(bus.array_caddr_wr), 0);
    chk("rst_wdata", bus.array_wdata_wr, 0);
`ifdef ARRAY_WR_ROW_CHECK_EN
    chk("rst_row_err", 64'(bus.wr_row_err), 0);
`endif
  endtask

  // Monitor: compares every strobe, precharge edge and done pulse to the scoreboard
  logic prev_cas = 1'b0;
  logic prev_bs  = 1'b1;
  always @(negedge clk) begin
    beat_t b;
    done_t d;
    if (!rst) begin
      if (bus.array_cas_wr) begin
        chk("cas_gap", 64'(prev_cas), 0);
        chk("cas_expected", 64'(beat_q.size() != 0), 1);
        if (beat_q.size() != 0) begin
          b = beat_q.pop_front();
          chk("cas_cycle", 64'(cyc), 64'(b.cyc));
          chk("caddr", 64'(bus.array_caddr_wr), 64'(b.caddr));
          chk("wdata", bus.array_wdata_wr, b.data);
`ifdef ARRAY_WR_ROW_CHECK_EN
          chk("row_err", 64'(bus.wr_row_err), 64'(b.err));
`endif
        end
      end
`ifdef ARRAY_WR_ROW_CHECK_EN
      if (bus.wr_row_err) chk("row_err_with_cas", 64'(bus.array_cas_wr), 1);
`endif
      if (!prev_bs && bus.array_banksel_n_wr) begin
        chk("precharge_expected", 64'(done_q.size() != 0), 1);
        if (done_q.size() != 0) chk("banksel_rise_cycle", 64'(cyc), 64'(done_q[0].rise));
      end
      if (bus.wr_done) begin
        chk("done_expected", 64'(done_q.size() != 0), 1);
        if (done_q.size() != 0) begin
          d = done_q.pop_front();
          chk("wr_done_cycle", 64'(cyc), 64'(d.done));
        end
      end
    end
    prev_cas = bus.array_cas_wr;
    prev_bs  = bus.array_banksel_n_wr;
  end

  // Async reset at a chosen cycle of a burst; outputs must clear within the cycle
  task automatic maybe_reset(input int tgt, input bit en, output bit hit);
    hit = 1'b0;
    if (en && cyc == tgt) begin
      hit = 1'b1;
      #2 rst = 1'b1;
      #1 chk_reset_vals();
      bus.axi_frame_wr_valid = 1'b0;
      beat_q.delete();
      done_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  // Drive the burst in f_addr/f_data; called on a negedge with the DUT idle
  task automatic send_burst(input int gap_at, input int rst_at, output bit aborted);
    int t0, hs, last_hs, n, w, p;
    bit hit;
    logic s, wb;
    logic [R-1:0] row0;
    beat_t b;
    done_t d;
    aborted = 1'b0;
    n = f_addr.size();
    t0 = cyc;
    row0 = f_addr[0][A-1 -: R];
    last_hs = t0;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && i == gap_at) begin
        bus.axi_frame_wr_valid = 1'b0;
        for (int g = 0; g < 5; g++) begin
          @(negedge clk);
          chk("gap_ready", 64'(bus.axi_frame_wr_ready), 1);
          chk("gap_no_cas", 64'(bus.array_cas_wr), 0);
        end
      end
      s  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      wb = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.axi_frame_wr_data  = {s, (i == n - 1), wb, f_addr[i], f_data[i]};
      bus.axi_frame_wr_valid = 1'b1;
      w = 0;
      while (!bus.axi_frame_wr_ready && w < MAXW) begin
        @(negedge clk);
        w++;
        maybe_reset(t0 + rst_at, rst_at >= 0, hit);
        if (hit) begin aborted = 1'b1; return; end
        if (i == 0 && cyc == t0 + 1) chk("banksel_low_after_detect", 64'(bus.array_banksel_n_wr), 0);
      end
      chk("handshake_seen", 64'(bus.axi_frame_wr_ready), 1);
      if (!bus.axi_frame_wr_ready) begin
        bus.axi_frame_wr_valid = 1'b0;
        aborted = 1'b1;
        return;
      end
      hs = cyc;
      if (i == 0) chk("first_handshake_cycle", 64'(hs), 64'(t0 + 1 + m1(trcd_v)));
      b.cyc   = hs + 1;
      b.caddr = f_addr[i][C-1:0];
      b.data  = f_data[i];
      b.err   = (i > 0) && (f_addr[i][A-1 -: R] != row0);
      beat_q.push_back(b);
      last_hs = hs;
      @(negedge clk);
      maybe_reset(t0 + rst_at, rst_at >= 0, hit);
      if (hit) begin aborted = 1'b1; return; end
    end
    bus.axi_frame_wr_valid = 1'b0;
    // Precharge starts once tWR after the last strobe and tRAS since activate both hold
    p = last_hs + 2 + m1(twr_v);
    if (t0 + 1 + tras_v > p) p = t0 + 1 + tras_v;
    d.rise = p;
    d.done = p + m1(trp_v);
    done_q.push_back(d);
  endtask

  task automatic run_burst(input int gap_at, input int rst_at);
    bit aborted;
    int w;
    send_burst(gap_at, rst_at, aborted);
    if (!aborted) begin
      w = 0;
      while (done_q.size() != 0 && w < MAXW) begin
        @(negedge clk);
        w++;
      end
      chk("burst_completed", 64'(done_q.size()), 0);
      done_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
    f_addr.delete();
    f_data.delete();
  endtask

  task automatic discard_frame();
    int t, w;
    t = cyc;
    bus.axi_frame_wr_data  = {1'b0, 1'b1, 1'b1, 20'd100, 64'hDEAD};
    bus.axi_frame_wr_valid = 1'b1;
    w = 0;
    while (!bus.axi_frame_wr_ready && w < MAXW) begin
      @(negedge clk);
      w++;
    end
    chk("discard_accept_cycle", 64'(cyc), 64'(t + 1));
    @(negedge clk);
    bus.axi_frame_wr_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("discard_quiet", {61'd0, bus.array_banksel_n_wr, bus.array_cas_wr, bus.wr_done}, 64'b100);
      @(negedge clk);
    end
  endtask

  initial begin
    bit ab;
    int n, gap;
    logic [R-1:0] row;
    bus.axi_frame_wr_valid = 1'b0;
    bus.axi_frame_wr_data  = '0;
    set_cfg(16, 6, 7, 4);
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame
    f_addr.push_back(20'd100); f_data.push_back(64'hA5);
    run_burst(0, -1);
    // Four-frame burst
    for (int i = 0; i < 4; i++) begin f_addr.push_back(20'(100 + i)); f_data.push_back(64'(32'hC0 + i)); end
    run_burst(0, -1);
    // Valid gap mid-burst
    for (int i = 0; i < 4; i++) begin f_addr.push_back(20'(200 + i)); f_data.push_back({$urandom, $urandom}); end
    run_burst(2, -1);
    // Non-sof frame in IDLE
    discard_frame();
    // Reset mid-burst, then a clean burst
    for (int i = 0; i < 4; i++) begin f_addr.push_back(20'(100 + i)); f_data.push_back(64'(i)); end
    run_burst(0, 11);
    f_addr.push_back(20'd100); f_data.push_back(64'hA5);
    run_burst(0, -1);
    // Second frame on a different row
    f_addr.push_back(20'((1 << 6) | 10)); f_data.push_back(64'h11);
    f_addr.push_back(20'((5 << 6) | 3));  f_data.push_back(64'h22);
    run_burst(0, -1);

    // Randomized bursts and timing configuration
    for (int k = 0; k < 20; k++) begin
      set_cfg($urandom_range(0, 40), $urandom_range(0, 8), $urandom_range(0, 10), $urandom_range(0, 6));
      @(negedge clk);
      n = $urandom_range(1, 6);
      row = R'($urandom);
      for (int i = 0; i < n; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0) f_addr.push_back({R'($urandom), C'($urandom)});
        else f_addr.push_back({row, C'($urandom)});
        f_data.push_back({$urandom, $urandom});
      end
      gap = (n > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : 0;
      run_burst(gap, -1);
    end
    ab = 1'b0;
    if (ab) $display("unused");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
